// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter.
package stopwatch_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE     = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/edge_sync.sv
// Level synchroniser followed by a one-cycle rising-edge pulse generator.
module edge_sync
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic input_clk,
    input  logic input_reset,
    input  logic input_level,
    output logic output_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync_out;

    assign w_sync_out  = r_sync[SYNC_STAGES-1];
    assign output_rise = w_sync_out & ~r_prev;

    // Shift the asynchronous level through the synchroniser and remember the last synced value.
    always_ff @(posedge input_clk or posedge input_reset) begin
        if (input_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], input_level};
            r_prev <= w_sync_out;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// BCD minutes:seconds stopwatch advanced by rising edges of a slow tick input.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MINUTES = 59
) (
    input  logic       input_clk,
    input  logic       input_reset,
    input  logic       input_tick,
    input  logic       input_start_stop,
    input  logic       input_clear,
    output logic [7:0] output_seconds,
    output logic [7:0] output_minutes,
    output logic       output_running,
    output logic       output_wrap
);

    // Last minutes value split into BCD digits for the wrap compare.
    localparam bcd_t MIN_TENS_MAX  = bcd_t'(MAX_MINUTES / 10);
    localparam bcd_t MIN_UNITS_MAX = bcd_t'(MAX_MINUTES % 10);

    state_t r_state;
    state_t w_state_nxt;
    bcd_t   r_sec_u, r_sec_t, r_min_u, r_min_t;
    bcd_t   w_sec_u, w_sec_t, w_min_u, w_min_t;
    logic   r_wrap;
    logic   w_wrap;
    logic   w_tick_rise;
    logic   w_count_en;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .input_clk  (input_clk),
        .input_reset(input_reset),
        .input_level(input_tick),
        .output_rise(w_tick_rise)
    );

    // Ticks are judged against the state held before any toggle in the same cycle.
    assign w_count_en = w_tick_rise && (r_state == RUNNING);

    // State register for the run/stop FSM.
    always_ff @(posedge input_clk or posedge input_reset) begin
        if (input_reset) begin
            r_state <= STOPPED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a start/stop pulse toggles between STOPPED and RUNNING.
    always_comb begin
        w_state_nxt = r_state;
        if (input_start_stop) begin
            w_state_nxt = (r_state == RUNNING) ? STOPPED : RUNNING;
        end
    end

    // Next count: clear beats increment; BCD digits ripple carries without a binary intermediate.
    always_comb begin
        w_sec_u = r_sec_u;
        w_sec_t = r_sec_t;
        w_min_u = r_min_u;
        w_min_t = r_min_t;
        w_wrap  = 1'b0;
        if (input_clear) begin
            w_sec_u = '0;
            w_sec_t = '0;
            w_min_u = '0;
            w_min_t = '0;
        end else if (w_count_en) begin
            if (r_sec_u != BCD_NINE) begin
                w_sec_u = r_sec_u + 4'd1;
            end else begin
                w_sec_u = '0;
                if (r_sec_t != SEC_TENS_MAX) begin
                    w_sec_t = r_sec_t + 4'd1;
                end else begin
                    w_sec_t = '0;
                    if ((r_min_t == MIN_TENS_MAX) && (r_min_u == MIN_UNITS_MAX)) begin
                        w_min_u = '0;
                        w_min_t = '0;
                        w_wrap  = 1'b1;
                    end else if (r_min_u != BCD_NINE) begin
                        w_min_u = r_min_u + 4'd1;
                    end else begin
                        w_min_u = '0;
                        w_min_t = r_min_t + 4'd1;
                    end
                end
            end
        end
    end

    // Count digits and the wrap pulse are registered so outputs have no input path.
    always_ff @(posedge input_clk or posedge input_reset) begin
        if (input_reset) begin
            r_sec_u <= '0;
            r_sec_t <= '0;
            r_min_u <= '0;
            r_min_t <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_sec_u <= w_sec_u;
            r_sec_t <= w_sec_t;
            r_min_u <= w_min_u;
            r_min_t <= w_min_t;
            r_wrap  <= w_wrap;
        end
    end

    assign output_seconds = {r_sec_t, r_sec_u};
    assign output_minutes = {r_min_t, r_min_u};
    assign output_running = (r_state == RUNNING);
    assign output_wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter (default and MAX_MINUTES=2 instances).
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ss = 1'b0;
    logic       ss2 = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] sec1, min1, sec2, min2;
    logic       run1, wrap1, run2, wrap2;

    int n_cmp = 0;
    int n_err = 0;
    int wcnt1 = 0;
    int wcnt2 = 0;

    always #5 clk = ~clk;

    stopwatch_counter #(.SYNC_STAGES(2), .MAX_MINUTES(59)) dut (
        .input_clk       (clk),
        .input_reset     (rst),
        .input_tick      (tick),
        .input_start_stop(ss),
        .input_clear     (clr),
        .output_seconds  (sec1),
        .output_minutes  (min1),
        .output_running  (run1),
        .output_wrap     (wrap1)
    );

    stopwatch_counter #(.SYNC_STAGES(2), .MAX_MINUTES(2)) dut2 (
        .input_clk       (clk),
        .input_reset     (rst),
        .input_tick      (tick),
        .input_start_stop(ss2),
        .input_clear     (clr),
        .output_seconds  (sec2),
        .output_minutes  (min2),
        .output_running  (run2),
        .output_wrap     (wrap2)
    );

    // Count cycles in which each wrap output was high.
    always @(posedge clk) begin
        if (wrap1) wcnt1 <= wcnt1 + 1;
        if (wrap2) wcnt2 <= wcnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic one_tick();
        tick = 1'b1;
        repeat (3) @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) one_tick();
    endtask

    task automatic pulse_ss();
        ss = 1'b1;
        @(negedge clk);
        ss = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_count", {16'h0, min1, sec1}, 32'h0000);
        check("rst_run", {31'h0, run1}, 32'h0);
        check("rst_wrap", {31'h0, wrap1}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Ticks while stopped are discarded
        ticks(5);
        check("stopped_count", {16'h0, min1, sec1}, 32'h0000);
        check("stopped_run", {31'h0, run1}, 32'h0);
        check("stopped_wrap", wcnt1, 0);

        // Start, then first-increment latency of 3 cycles
        pulse_ss();
        check("start_run", {31'h0, run1}, 32'h1);
        tick = 1'b1;
        repeat (2) @(negedge clk);
        check("lat_e2", {16'h0, min1, sec1}, 32'h0000);
        @(negedge clk);
        check("lat_e3", {16'h0, min1, sec1}, 32'h0001);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        ticks(60);
        check("count_61", {16'h0, min1, sec1}, 32'h0101);

        // Clear, then clear coinciding with tick_rise at 00:07
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clear", {16'h0, min1, sec1}, 32'h0000);
        check("clear_run", {31'h0, run1}, 32'h1);
        ticks(7);
        check("at_07", {16'h0, min1, sec1}, 32'h0007);
        tick = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_vs_tick", {16'h0, min1, sec1}, 32'h0000);
        tick = 1'b0;
        repeat (3) @(negedge clk);

        // Start/stop coinciding with tick_rise while running
        ticks(7);
        tick = 1'b1;
        repeat (2) @(negedge clk);
        pulse_ss();
        check("ss_vs_tick_cnt", {16'h0, min1, sec1}, 32'h0008);
        check("ss_vs_tick_run", {31'h0, run1}, 32'h0);
        tick = 1'b0;
        repeat (3) @(negedge clk);

        // Clear together with start/stop: both act
        clr = 1'b1;
        ss  = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        ss  = 1'b0;
        check("clr_ss_cnt", {16'h0, min1, sec1}, 32'h0000);
        check("clr_ss_run", {31'h0, run1}, 32'h1);

        // Stop / resume
        ticks(10);
        check("at_10", {16'h0, min1, sec1}, 32'h0010);
        pulse_ss();
        check("stop_run", {31'h0, run1}, 32'h0);
        ticks(3);
        check("stopped_hold", {16'h0, min1, sec1}, 32'h0010);
        pulse_ss();
        ticks(2);
        check("resume_12", {16'h0, min1, sec1}, 32'h0012);

        // Full wrap at MAX_MINUTES=59
        ticks(588);
        check("at_1000", {16'h0, min1, sec1}, 32'h1000);
        ticks(2999);
        check("at_5959", {16'h0, min1, sec1}, 32'h5959);
        check("no_wrap_yet", wcnt1, 0);
        tick = 1'b1;
        repeat (3) @(negedge clk);
        check("wrap_cnt", {16'h0, min1, sec1}, 32'h0000);
        check("wrap_hi", {31'h0, wrap1}, 32'h1);
        @(negedge clk);
        check("wrap_lo", {31'h0, wrap1}, 32'h0);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        check("wrap_once", wcnt1, 1);

        // Wrap at MAX_MINUTES=2 on the second instance
        check("dut2_idle", {15'h0, run2, min2, sec2}, 32'h0000);
        ss2 = 1'b1;
        @(negedge clk);
        ss2 = 1'b0;
        ticks(179);
        check("dut2_0259", {16'h0, min2, sec2}, 32'h0259);
        check("dut2_no_wrap", wcnt2, 0);
        tick = 1'b1;
        repeat (3) @(negedge clk);
        check("dut2_wrap_cnt", {16'h0, min2, sec2}, 32'h0000);
        check("dut2_wrap_hi", {31'h0, wrap2}, 32'h1);
        @(negedge clk);
        check("dut2_wrap_lo", {31'h0, wrap2}, 32'h0);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        check("dut2_wrap_once", wcnt2, 1);
        check("dut1_0300", {16'h0, min1, sec1}, 32'h0300);

        // Asynchronous reset mid-count at 12:34
        ticks(574);
        check("at_1234", {16'h0, min1, sec1}, 32'h1234);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_cnt", {16'h0, min1, sec1}, 32'h0000);
        check("async_run", {31'h0, run1}, 32'h0);
        check("async_wrap", {31'h0, wrap1}, 32'h0);
        check("async_dut2", {15'h0, run2, min2, sec2}, 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ticks(3);
        check("post_rst_stopped", {16'h0, min1, sec1}, 32'h0000);
        pulse_ss();
        ticks(1);
        check("post_rst_count", {16'h0, min1, sec1}, 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
